line_window_gen: RTL and testbench

//  Parametrised successor to the fixed 4-bank line memory. Accepts a raster

---
 rtl/conv_pkg.sv | 21 ++
 rtl/line_bank.sv | 27 ++
 rtl/line_window_gen.sv | 187 ++++++++++++++++++
 tb/tb_line_window_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared defaults, window indexing helper and FSM state type for the
// line-buffered window generator.
package conv_pkg;

  localparam int KS_DEF = 3;
  localparam int PB_DEF = 8;
  localparam int XB_DEF = 10;
  localparam int YB_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Flat pixel slot of window element (row r, column c); row 0 / col 0 is oldest.
  function automatic int win_idx(input int ks, input int r, input int c);
    return r * ks + c;
  endfunction

endpackage

// File: rtl/line_bank.sv
// One line of pixel history: simple dual-port RAM, registered read,
// read-first when both ports hit the same address.
module line_bank #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_window_gen.sv
// Raster pixel stream in, one KSxKS window per interior pixel out, using
// KS-1 rotating line banks and a single output register stage.
module line_window_gen
  import conv_pkg::*;
#(
  parameter int XB = XB_DEF,
  parameter int YB = YB_DEF,
  parameter int PB = PB_DEF,
  parameter int KS = KS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XB-1:0]       cfg_width,
  input  logic [YB-1:0]       cfg_height,
  input  logic [PB-1:0]       px_in_data,
  input  logic                px_in_valid,
  output logic                px_in_ready,
  output logic [KS*KS*PB-1:0] px_out_data,
  output logic                px_out_valid,
  input  logic                px_out_ready,
  output logic                px_out_last_x,
  output logic                px_out_last_y,
  output logic                done,
  output logic                cfg_err
);

  localparam int NB = KS - 1;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;

  state_e        state_q, state_d;
  logic [XB-1:0] x_q, x_d, w_q, w_d, width_cur;
  logic [YB-1:0] y_q, y_d, h_q, h_d, height_cur;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          cfg_err_q, cfg_err_d;
  logic          valid_q, valid_d;
  logic          last_x_q, last_x_d, last_y_q, last_y_d;
  logic          done_q, done_d;
  logic          cfg_bad, out_free, accept, x_end, y_end, emit;

  logic [PB-1:0] bank_rd [NB];
  logic [PB-1:0] col     [KS];
  logic [PB-1:0] win_q   [KS][KS];

  assign cfg_bad  = (cfg_width < XB'(KS)) || (cfg_height < YB'(KS));
  assign out_free = !valid_q || px_out_ready;
  // The cfg_bad term covers the first IDLE cycle before cfg_err_q catches up.
  assign px_in_ready = (state_q != ST_DRAIN) && out_free && !cfg_err_q &&
                       !((state_q == ST_IDLE) && cfg_bad);
  assign accept = px_in_valid && px_in_ready;

  assign width_cur  = (state_q == ST_IDLE) ? cfg_width  : w_q;
  assign height_cur = (state_q == ST_IDLE) ? cfg_height : h_q;
  assign x_end = (x_q == width_cur - XB'(1));
  assign y_end = (y_q == height_cur - YB'(1));
  assign emit  = (x_q >= XB'(KS - 1)) && (y_q >= YB'(KS - 1));

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    ptr_d     = ptr_q;
    cfg_err_d = cfg_err_q;
    valid_d   = valid_q && !px_out_ready;
    last_x_d  = last_x_q;
    last_y_d  = last_y_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_err_d = cfg_bad;
        if (accept) begin
          w_d     = cfg_width;
          h_d     = cfg_height;
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (valid_q && px_out_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (accept) begin
      valid_d  = emit;
      last_x_d = x_end;
      last_y_d = y_end;
      if (x_end) begin
        x_d = '0;
        if (y_end) begin
          y_d     = '0;
          ptr_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          y_d   = y_q + YB'(1);
          ptr_d = (ptr_q == PW'(NB - 1)) ? '0 : ptr_q + PW'(1);
        end
      end else begin
        x_d = x_q + XB'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      ptr_q     <= '0;
      cfg_err_q <= 1'b0;
      valid_q   <= 1'b0;
      last_x_q  <= 1'b0;
      last_y_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      ptr_q     <= ptr_d;
      cfg_err_q <= cfg_err_d;
      valid_q   <= valid_d;
      last_x_q  <= last_x_d;
      last_y_q  <= last_y_d;
      done_q    <= done_d;
    end
  end

  // Banks are read at the next column address so the registered read data
  // lines up with the pixel accepted in the following cycle.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      logic [PW:0]   sum;
      logic [PW-1:0] sel;
      line_bank #(.AW(XB), .DW(PB)) u_bank (
        .clk_i   (clk),
        .we_i    (accept && (ptr_q == PW'(gi))),
        .waddr_i (x_q),
        .wdata_i (px_in_data),
        .raddr_i (x_d),
        .rdata_o (bank_rd[gi])
      );
      assign sum = {1'b0, ptr_q} + (PW+1)'(gi);
      assign sel = (sum >= (PW+1)'(NB)) ? PW'(sum - (PW+1)'(NB)) : PW'(sum);
      assign col[gi] = bank_rd[sel];
    end
  endgenerate
  assign col[KS-1] = px_in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < KS; r++) begin
        for (int c = 0; c < KS; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < KS; r++) begin
        for (int c = 0; c < KS - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][KS-1] <= col[r];
      end
    end
  end

  generate
    for (gi = 0; gi < KS; gi++) begin : g_row
      for (gj = 0; gj < KS; gj++) begin : g_col_out
        assign px_out_data[win_idx(KS, gi, gj)*PB +: PB] = win_q[gi][gj];
      end
    end
  endgenerate

  assign px_out_valid  = valid_q;
  assign px_out_last_x = last_x_q;
  assign px_out_last_y = last_y_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench: feeder pushes expected windows computed from the frame
// image, an independent monitor pops and compares on every output handshake.
module tb_line_window_gen;

  localparam int KS = 3;
  localparam int PB = 8;
  localparam int XB = 10;
  localparam int YB = 10;
  localparam int WB = KS * KS * PB;

  typedef struct packed {
    logic [WB-1:0] data;
    logic          lx;
    logic          ly;
  } win_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XB-1:0] cfg_width = XB'(5);
  logic [YB-1:0] cfg_height = YB'(4);
  logic [PB-1:0] px_in_data = '0;
  logic          px_in_valid = 1'b0;
  logic          px_in_ready;
  logic [WB-1:0] px_out_data;
  logic          px_out_valid;
  logic          px_out_ready = 1'b1;
  logic          px_out_last_x;
  logic          px_out_last_y;
  logic          done;
  logic          cfg_err;

  line_window_gen #(.XB(XB), .YB(YB), .PB(PB), .KS(KS)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .px_in_data    (px_in_data),
    .px_in_valid   (px_in_valid),
    .px_in_ready   (px_in_ready),
    .px_out_data   (px_out_data),
    .px_out_valid  (px_out_valid),
    .px_out_ready  (px_out_ready),
    .px_out_last_x (px_out_last_x),
    .px_out_last_y (px_out_last_y),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  logic [PB-1:0] img [16][16];
  win_t          exp_q [$];
  int            vec = 0;
  int            miss = 0;
  int            win_rcv = 0;
  int            done_cnt = 0;
  int            rdy_mode = 0;
  logic          done_exp = 1'b0;
  logic          prev_stall = 1'b0;
  logic [WB-1:0] prev_data = '0;

  task automatic chk_bit(input string name, input logic got, input logic want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %0b expected %0b", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    vec++;
    if (got != want) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_win(input string name, input win_t got, input win_t want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got data=%h lx=%0b ly=%0b expected data=%h lx=%0b ly=%0b",
               name, got.data, got.lx, got.ly, want.data, want.lx, want.ly);
    end
  endtask

  // Window for pixel (x,y): element (r,c) = image pixel (y-KS+1+r, x-KS+1+c).
  function automatic logic [WB-1:0] model_win(input int x, input int y);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < KS; r++) begin
      for (int c = 0; c < KS; c++) begin
        w[(r*KS+c)*PB +: PB] = img[y-KS+1+r][x-KS+1+c];
      end
    end
    return w;
  endfunction

  // Downstream ready: 0 always-on, 1 toggling, 2 random, 3 always-off.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       px_out_ready = 1'b1;
      1:       px_out_ready = ~px_out_ready;
      2:       px_out_ready = ($urandom_range(99) < 60);
      default: px_out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    win_t got, want;
    if (rst) begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end else begin
      if (done || done_exp) chk_bit("done_pulse", done, done_exp);
      if (done) done_cnt++;
      done_exp = 1'b0;
      if (prev_stall) begin
        chk_bit("stall_valid", px_out_valid, 1'b1);
        vec++;
        if (px_out_data !== prev_data) begin
          miss++;
          $display("FAIL stall_data: got %h expected %h", px_out_data, prev_data);
        end
      end
      prev_stall = 1'b0;
      if (px_out_valid && !px_out_ready) begin
        chk_bit("in_ready_stall", px_in_ready, 1'b0);
        prev_stall = 1'b1;
        prev_data  = px_out_data;
      end
      if (px_out_valid && px_out_ready) begin
        got = '{data: px_out_data, lx: px_out_last_x, ly: px_out_last_y};
        if (exp_q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL unexpected_window: got data=%h with empty scoreboard", got.data);
        end else begin
          want = exp_q.pop_front();
          chk_win("window", got, want);
          $display("win %0d: data=%h last_x=%0b last_y=%0b", win_rcv, got.data, got.lx, got.ly);
          if (want.lx && want.ly) done_exp = 1'b1;
        end
        win_rcv++;
      end
    end
  end

  // Streams one frame; abort_n >= 0 stops after that many pixels and resets.
  task automatic run_frame(input int w, input int h, input bit rnd_pix,
                           input int vld_pct, input int abort_n);
    int   d0, budget, x, y;
    bit   acc;
    win_t e;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        img[yy][xx] = rnd_pix ? PB'($urandom) : PB'(yy * 16 + xx);
      end
    end
    cfg_width  = XB'(w);
    cfg_height = YB'(h);
    win_rcv    = 0;
    d0         = done_cnt;
    for (int i = 0; i < w * h && i != abort_n; i++) begin
      x = i % w;
      y = i / w;
      while ($urandom_range(99) >= vld_pct) begin
        px_in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      px_in_valid = 1'b1;
      px_in_data  = img[y][x];
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = px_in_ready;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) begin
        chk_bit("in_accept_timeout", 1'b0, 1'b1);
        px_in_valid = 1'b0;
        return;
      end
      if (x >= KS - 1 && y >= KS - 1) begin
        e = '{data: model_win(x, y), lx: (x == w - 1), ly: (y == h - 1)};
        exp_q.push_back(e);
      end
    end
    px_in_valid = 1'b0;
    if (abort_n >= 0) begin
      chk_bit("pre_rst_valid", px_out_valid, exp_q.size() != 0);
      rst = 1'b1;
      #1;
      chk_bit("rst_valid", px_out_valid, 1'b0);
      chk_bit("rst_last_x", px_out_last_x, 1'b0);
      chk_bit("rst_last_y", px_out_last_y, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      chk_bit("rst_cfg_err", cfg_err, 1'b0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      return;
    end
    budget = 0;
    while (!(exp_q.size() == 0 && done_cnt != d0) && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk_int("frame_windows", win_rcv, (w - KS + 1) * (h - KS + 1));
    chk_int("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_valid", px_out_valid, 1'b0);
    chk_bit("reset_last_x", px_out_last_x, 1'b0);
    chk_bit("reset_last_y", px_out_last_y, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    rdy_mode = 0;
    run_frame(5, 4, 1'b0, 100, -1);
    rdy_mode = 1;
    run_frame(5, 4, 1'b0, 100, -1);
    rdy_mode = 0;
    run_frame(3, 3, 1'b0, 100, -1);

    cfg_width   = XB'(2);
    cfg_height  = YB'(4);
    px_in_valid = 1'b1;
    px_in_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk_bit("cfg_err_width", cfg_err, 1'b1);
    chk_bit("cfg_err_ready", px_in_ready, 1'b0);
    chk_bit("cfg_err_no_out", px_out_valid, 1'b0);
    cfg_width  = XB'(5);
    cfg_height = YB'(2);
    repeat (2) @(posedge clk);
    #1;
    chk_bit("cfg_err_height", cfg_err, 1'b1);
    chk_bit("cfg_err_ready_h", px_in_ready, 1'b0);
    px_in_valid = 1'b0;
    cfg_height  = YB'(4);
    repeat (2) @(posedge clk);
    #1;
    chk_bit("cfg_err_cleared", cfg_err, 1'b0);
    run_frame(5, 4, 1'b0, 100, -1);

    run_frame(5, 4, 1'b0, 100, 9);
    run_frame(5, 4, 1'b0, 100, -1);
    rdy_mode = 3;
    run_frame(5, 4, 1'b0, 100, 13);
    rdy_mode = 0;

    run_frame(5, 4, 1'b0, 100, -1);
    run_frame(8, 3, 1'b0, 100, -1);

    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      run_frame($urandom_range(12, 3), $urandom_range(8, 3), 1'b1, 70, -1);
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
